// File: rtl/pixel_pack_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pack_pkg
// Shared constants and helpers for the pixel packer:
//   PIX_W          - bits per pixel (fixed at 4)
//   WORD_W         - packed byte width (two pixels)
//   FIRST_PIX_HIGH - nibble order: first pixel of a pair in the high nibble
//   level_width()  - width of an occupancy counter able to hold 0..depth
//   pack_pair()    - assemble a byte from two pixels in the chosen order
// ---------------------------------------------------------------------------
package pixel_pack_pkg;

    localparam int PIX_W          = 4;
    localparam int WORD_W         = 2 * PIX_W;
    localparam int FIRST_PIX_HIGH = 1;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [WORD_W-1:0] pack_pair(input logic [PIX_W-1:0] first_pix,
                                                    input logic [PIX_W-1:0] second_pix);
        if (FIRST_PIX_HIGH != 0) begin
            return {first_pix, second_pix};
        end
        return {second_pix, first_pix};
    endfunction

endpackage

// File: rtl/pixel_pack_fifo_if.sv
// ---------------------------------------------------------------------------
// pixel_pack_fifo_if
// Bundles the pixel-side and framebuffer-side handshakes of pixel_pack_fifo.
//   flush                          - synchronous frame-start clear
//   pix_valid/pix_data/pix_last    - pixel stream from the engine
//   pix_ready                      - packer can take a pixel this cycle
//   word_valid/word_data/word_ack  - packed-byte stream to the framebuffer
//   level                          - bytes held in the FIFO
//   overflow                       - sticky dropped-pixel flag
// Optional (PIXEL_PACK_FRAME_CNT_EN): frame_pixels, frame_done.
// Modports: slave = the packer itself, master = the surrounding system.
// ---------------------------------------------------------------------------
interface pixel_pack_fifo_if #(
    parameter int DEPTH = 4
);
    import pixel_pack_pkg::*;

    localparam int LVL_W = level_width(DEPTH);

    logic              flush;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_last;
    logic              pix_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ack;
    logic [LVL_W-1:0]  level;
    logic              overflow;
`ifdef PIXEL_PACK_FRAME_CNT_EN
    logic [15:0]       frame_pixels;
    logic              frame_done;
`endif

    modport slave (
        input  flush, pix_valid, pix_data, pix_last, word_ack,
`ifdef PIXEL_PACK_FRAME_CNT_EN
        output frame_pixels, frame_done,
`endif
        output pix_ready, word_valid, word_data, level, overflow
    );

    modport master (
        output flush, pix_valid, pix_data, pix_last, word_ack,
`ifdef PIXEL_PACK_FRAME_CNT_EN
        input  frame_pixels, frame_done,
`endif
        input  pix_ready, word_valid, word_data, level, overflow
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Generic first-word-fall-through FIFO. The head entry is always visible on
// o_rdata; occupancy is tracked by a level counter and full/empty derive
// from it, so pointers wrap freely modulo DEPTH (DEPTH is a power of two).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - synchronous clear, overrides push and pop
//   i_push      - write i_wdata (ignored when full)
//   i_pop       - drop head entry (ignored when empty)
//   o_rdata     - head entry
//   o_level     - entries held
//   o_full/o_empty
// ---------------------------------------------------------------------------
module sync_fifo_fwft
    import pixel_pack_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [LVL_W-1:0] o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_push && !w_full && !i_clear;
    assign w_pop   = i_pop && !w_empty && !i_clear;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/pixel_pack_fifo.sv
// ---------------------------------------------------------------------------
// pixel_pack_fifo
// Packs 4-bit pixel iteration counts two per byte (first pixel in the high
// nibble) and buffers the bytes in a FWFT FIFO for the framebuffer port.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - pixel_pack_fifo_if.slave: pixel stream in, byte stream out,
//            flush, level and sticky overflow
// Build option: define PIXEL_PACK_FRAME_CNT_EN to add frame_pixels (accepted
// pixels since flush/reset, saturating) and frame_done (pulse the cycle
// after the last pixel of a frame is accepted).
// ---------------------------------------------------------------------------
module pixel_pack_fifo
    import pixel_pack_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    pixel_pack_fifo_if.slave  bus
);

    logic             r_half;
    logic [PIX_W-1:0] r_pend;
    logic             r_overflow;

    logic              w_pix_ready;
    logic              w_accept;
    logic              w_push;
    logic [WORD_W-1:0] w_word;
    logic              w_lost_last;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [LVL_W-1:0]  w_level;
    logic [WORD_W-1:0] w_head;

    // A first nibble only needs the half-slot, so it is taken even when the
    // FIFO is full. Registered state only: a same-cycle pop frees nothing.
    assign w_pix_ready = !r_half || !w_fifo_full;
    assign w_accept    = bus.pix_valid && w_pix_ready;

    always_comb begin
        w_push = 1'b0;
        w_word = pack_pair(r_pend, bus.pix_data);
        if (w_accept) begin
            if (r_half) begin
                w_push = 1'b1;
            end else if (bus.pix_last) begin
                w_push = 1'b1;
                w_word = pack_pair(bus.pix_data, {PIX_W{1'b0}});
            end
        end
    end

    // An odd final pixel arriving with the FIFO full has nowhere to go; it
    // is lost and flagged like any other dropped pixel.
    assign w_lost_last = w_accept && !r_half && bus.pix_last && w_fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half     <= 1'b0;
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            r_half     <= 1'b0;
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_half) begin
                    r_half <= 1'b0;
                end else if (!bus.pix_last) begin
                    r_half <= 1'b1;
                    r_pend <= bus.pix_data;
                end
            end
            if ((bus.pix_valid && !w_pix_ready) || w_lost_last) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (bus.word_ack),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.pix_ready  = w_pix_ready;
    assign bus.word_valid = !w_fifo_empty;
    assign bus.word_data  = w_head;
    assign bus.level      = w_level;
    assign bus.overflow   = r_overflow;

`ifdef PIXEL_PACK_FRAME_CNT_EN
    logic [15:0] r_frame_pixels;
    logic        r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_pixels <= '0;
            r_frame_done   <= 1'b0;
        end else if (bus.flush) begin
            r_frame_pixels <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            if (w_accept && (r_frame_pixels != 16'hFFFF)) begin
                r_frame_pixels <= r_frame_pixels + 16'd1;
            end
            r_frame_done <= w_accept && bus.pix_last;
        end
    end

    assign bus.frame_pixels = r_frame_pixels;
    assign bus.frame_done   = r_frame_done;
`endif

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// ---------------------------------------------------------------------------
// tb_pixel_pack_fifo
// Directed bench for pixel_pack_fifo (DEPTH=4). Expected bytes are pushed to
// a scoreboard queue as pixels are driven and compared when acked; a small
// reference model tracks level, half-slot, overflow and frame counters.
// Frame-counter checks are included when PIXEL_PACK_FRAME_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pixel_pack_fifo;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pixel_pack_fifo_if #(.DEPTH(DEPTH)) bus ();

    pixel_pack_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q [$];
    bit         m_half;
    logic [3:0] m_pend;
    bit         m_ovf;
    int         m_cnt;
    bit         m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return !m_half || (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_half = 0;
        m_pend = '0;
        m_ovf  = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    task automatic post_check();
        check("level", 32'(bus.level), 32'(m_q.size()));
        check("word_valid", 32'(bus.word_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("word_data", 32'(bus.word_data), 32'(m_q[0]));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("pix_ready", 32'(bus.pix_ready), 32'(model_ready()));
`ifdef PIXEL_PACK_FRAME_CNT_EN
        check("frame_pixels", 32'(bus.frame_pixels), 32'(m_cnt));
        check("frame_done", 32'(bus.frame_done), 32'(m_done));
`endif
    endtask

    // One clock of stimulus: drive, update the model, clock, check.
    task automatic cycle(input bit pv, input logic [3:0] pd, input bit pl,
                         input bit ack, input bit fl);
        int pre;
        bit acc;
        pre = m_q.size();
        bus.pix_valid = pv;
        bus.pix_data  = pd;
        bus.pix_last  = pl;
        bus.word_ack  = ack;
        bus.flush     = fl;
        if (ack && pre > 0 && !fl) check("sb_head", 32'(bus.word_data), 32'(m_q[0]));
        acc = pv && (!m_half || pre < DEPTH);
        m_done = 0;
        if (fl) begin
            model_reset();
        end else begin
            if (ack && pre > 0) void'(m_q.pop_front());
            if (pv && !acc) m_ovf = 1;
            if (acc) begin
                if (m_cnt < 65535) m_cnt++;
                m_done = pl;
                if (m_half) begin
                    m_q.push_back({m_pend, pd});
                    m_half = 0;
                end else if (pl) begin
                    if (pre < DEPTH) m_q.push_back({pd, 4'h0});
                    else m_ovf = 1;
                end else begin
                    m_pend = pd;
                    m_half = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.word_ack  = 1'b0;
        bus.flush     = 1'b0;
        post_check();
    endtask

    initial begin
        int pulses;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_last  = 1'b0;
        bus.word_ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word_data", 32'(bus.word_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        rst_n = 1'b1;

        // Basic pack
        cycle(1, 4'hA, 0, 0, 0);
        cycle(1, 4'h5, 0, 0, 0);
        check("basic_byte", 32'(bus.word_data), 32'h A5);
        check("basic_level", 32'(bus.level), 32'd1);
        cycle(0, 4'h0, 0, 1, 0);
        check("basic_drained", 32'(bus.word_valid), 32'd0);
        $display("[TB] basic pack done");

        // Odd last pixel
        cycle(1, 4'h3, 1, 0, 0);
        check("odd_byte", 32'(bus.word_data), 32'h30);
        cycle(1, 4'h6, 0, 0, 0);
        cycle(1, 4'h7, 0, 1, 0);
        check("odd_then_pair", 32'(bus.word_data), 32'h67);
        cycle(0, 4'h0, 0, 1, 0);
        $display("[TB] odd last done");

        // Fill and overflow
        for (int i = 1; i <= 8; i++) cycle(1, 4'(i), 0, 0, 0);
        check("fill_level", 32'(bus.level), 32'd4);
        cycle(1, 4'h9, 0, 0, 0);
        check("fill_9th_ready_low", 32'(bus.pix_ready), 32'd0);
        cycle(1, 4'hA, 0, 0, 0);
        check("fill_overflow", 32'(bus.overflow), 32'd1);
        check("fill_level_held", 32'(bus.level), 32'd4);
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 0, 1, 0);
        cycle(0, 4'h0, 0, 0, 1);
        $display("[TB] fill/overflow done");

        // Simultaneous push/pop at level 2, across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1, 4'(4'hB + i), 0, 0, 0);
        for (int i = 0; i < 14; i++) cycle(1, 4'(i * 3), 0, (i % 2) == 1, 0);
        check("pp_level", 32'(bus.level), 32'd2);
        for (int i = 0; i < 2; i++) cycle(0, 4'h0, 0, 1, 0);
        $display("[TB] push/pop wrap done");

        // Flush mid-byte
        cycle(1, 4'hD, 0, 0, 0);
        cycle(1, 4'hE, 0, 0, 0);
        cycle(1, 4'hC, 0, 0, 0);
        cycle(1, 4'h7, 0, 1, 1);
        check("flush_level", 32'(bus.level), 32'd0);
        cycle(1, 4'h1, 0, 0, 0);
        cycle(1, 4'h2, 0, 0, 0);
        check("flush_byte", 32'(bus.word_data), 32'h12);
        cycle(0, 4'h0, 0, 1, 0);
        $display("[TB] flush mid-byte done");

        // Async reset mid-operation
        for (int i = 0; i < 6; i++) cycle(1, 4'(i + 2), 0, 0, 0);
        check("areset_pre_level", 32'(bus.level), 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_level", 32'(bus.level), 32'd0);
        check("areset_word_valid", 32'(bus.word_valid), 32'd0);
        check("areset_word_data", 32'(bus.word_data), 32'd0);
        check("areset_pix_ready", 32'(bus.pix_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        $display("[TB] async reset done");

`ifdef PIXEL_PACK_FRAME_CNT_EN
        cycle(0, 4'h0, 0, 0, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4'(i + 1), i == 4, 1, 0);
            pulses += int'(bus.frame_done);
        end
        check("frame_pixels", 32'(bus.frame_pixels), 32'd5);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'h0, 0, 1, 0);
            pulses += int'(bus.frame_done);
        end
        check("frame_done_pulses", 32'(pulses), 32'd1);
        $display("[TB] frame counter done");
`else
        pulses = 0;
        cycle(0, 4'h0, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
